// File: rtl/univ_shift_reg.sv
// Universal shift register: parallel load, shift/rotate both ways, synchronous clear,
// and a counted burst of left shifts run by a two-state FSM.
module univ_shift_reg #(
    parameter int                 WIDTH     = 8,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0,
    parameter int                 CW        = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             res,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin,
    input  logic [CW-1:0]    cnt,
    output logic [WIDTH-1:0] q,
    output logic             sout,
    output logic             busy,
    output logic             done
);

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    localparam logic [2:0] MODE_HOLD  = 3'b000;
    localparam logic [2:0] MODE_LOAD  = 3'b001;
    localparam logic [2:0] MODE_SHL   = 3'b010;
    localparam logic [2:0] MODE_SHR   = 3'b011;
    localparam logic [2:0] MODE_ROL   = 3'b100;
    localparam logic [2:0] MODE_ROR   = 3'b101;
    localparam logic [2:0] MODE_BURST = 3'b110;
    localparam logic [2:0] MODE_CLEAR = 3'b111;

    state_t           state, state_nxt;
    logic [CW-1:0]    remaining, remaining_nxt;
    logic [WIDTH-1:0] q_nxt;
    logic             done_nxt;
    logic [CW-1:0]    cnt_sat;

    // Bursts longer than the register cannot do more than replace every bit.
    assign cnt_sat = (cnt > CW'(WIDTH)) ? CW'(WIDTH) : cnt;

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state     <= IDLE;
            q         <= RESET_VAL;
            remaining <= '0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            q         <= q_nxt;
            remaining <= remaining_nxt;
            done      <= done_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        q_nxt         = q;
        remaining_nxt = remaining;
        done_nxt      = 1'b0;
        if (en) begin
            case (state)
                IDLE: begin
                    case (mode)
                        MODE_HOLD:  q_nxt = q;
                        MODE_LOAD:  q_nxt = d;
                        MODE_SHL:   q_nxt = {q[WIDTH-2:0], sin};
                        MODE_SHR:   q_nxt = {sin, q[WIDTH-1:1]};
                        MODE_ROL:   q_nxt = {q[WIDTH-2:0], q[WIDTH-1]};
                        MODE_ROR:   q_nxt = {q[0], q[WIDTH-1:1]};
                        MODE_BURST: begin
                            if (cnt == '0) begin
                                done_nxt = 1'b1;
                            end else begin
                                state_nxt     = BURST;
                                remaining_nxt = cnt_sat;
                            end
                        end
                        MODE_CLEAR: q_nxt = RESET_VAL;
                        default:    q_nxt = q;
                    endcase
                end
                BURST: begin
                    // Only a clear interrupts a burst; it ends silently without done.
                    if (mode == MODE_CLEAR) begin
                        q_nxt         = RESET_VAL;
                        state_nxt     = IDLE;
                        remaining_nxt = '0;
                    end else begin
                        q_nxt         = {q[WIDTH-2:0], sin};
                        remaining_nxt = remaining - CW'(1);
                        if (remaining == CW'(1)) begin
                            state_nxt = IDLE;
                            done_nxt  = 1'b1;
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        busy = (state == BURST);
        sout = q[WIDTH-1];
    end

endmodule

// File: doc/univ_shift_reg.md
UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

Interface
REQ-001 Parameter WIDTH, default 8, data register width; legal range 2..32.
REQ-002 Parameter RESET_VAL, default 0, WIDTH-bit value loaded into q on reset.
REQ-003 Derived constant CW = $clog2(WIDTH+1), width of the burst count.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 res  input  1  reset, asynchronous, active-low.
REQ-006 en  input  1  clock enable; 0 freezes all state (q, burst counter, FSM).
REQ-007 mode  input  3  operation select, sampled on a rising edge with en=1.
REQ-008 d  input  WIDTH  parallel load data.
REQ-009 sin  input  1  serial input bit for shift operations.
REQ-010 cnt  input  CW  burst shift count, sampled only when a burst is accepted.
REQ-011 q  output  WIDTH  registered data.
REQ-012 sout  output  1  serial output, combinationally equal to q[WIDTH-1].
REQ-013 busy  output  1  registered, 1 while FSM is in BURST.
REQ-014 done  output  1  registered one-cycle pulse marking burst completion.

Function
REQ-015 mode decode in IDLE when en=1: 000 hold; 001 q<=d; 010 shift left, q<={q[WIDTH-2:0],sin}; 011 shift right, q<={sin,q[WIDTH-1:1]}; 100 rotate left; 101 rotate right; 110 burst request; 111 synchronous clear, q<=RESET_VAL.
REQ-016 FSM states: IDLE, BURST; no other states are reachable.
REQ-017 IDLE to BURST on a rising edge with en=1, mode=110, cnt!=0; that edge loads remaining<=cnt and leaves q unchanged; busy=1 from the next cycle.
REQ-018 A burst request with cnt=0 leaves q and the state unchanged, and done=1 for exactly the next cycle.
REQ-019 In BURST, each rising edge with en=1 performs one shift left with sin and decrements remaining.
REQ-020 In BURST, en=0 pauses the burst: q and remaining hold, busy stays 1.
REQ-021 The edge that performs the last shift (remaining 1 to 0) returns the FSM to IDLE, clears busy and sets done=1 for one cycle.
REQ-022 Total latency is cnt+1 enabled edges from burst acceptance to done; q then equals the initial q shifted left cnt places, with the sampled sin bits filling from bit 0.
REQ-023 cnt values above WIDTH are saturated to WIDTH, so q is fully replaced by sin bits.
REQ-024 In BURST, modes 000..110 are ignored; mode=111 with en=1 aborts the burst: q<=RESET_VAL, state IDLE, busy<=0, no done pulse.
REQ-025 done is 0 in every cycle not covered by REQ-018 or REQ-021; busy and done are never both 1.
REQ-026 There is no combinational path from any input to q, busy or done; sout depends only on q.

Reset
REQ-027 res=0 forces immediately, without a clock edge: q=RESET_VAL, state IDLE, remaining=0, busy=0, done=0.
REQ-028 Reset asserted mid-burst abandons the burst with no done pulse; after release the block is in IDLE.
REQ-029 The first operation after res rises is accepted on the first rising edge with en=1.

Verification
REQ-030 Reset and hold (WIDTH=8): res=0, then release; apply mode=000, en=1 for 3 edges -> q=8'h00, busy=0, done=0 throughout; drive res=0 between edges -> q=0 with no edge.
REQ-031 Load and enable: en=1, mode=001, d=8'hA5 -> q=8'hA5; next edge with en=0, d=8'hFF -> q stays 8'hA5.
REQ-032 Shift and rotate: start from q=8'h81. Rotate left -> 8'h03. Rotate right (from 8'h81) -> 8'hC0. Shift right with sin=0 (from 8'h81) -> 8'h40. Shift left with sin=1 (from 8'h81) -> 8'h03. sout equals q[7] in every case.
REQ-033 Burst: q=8'h0F, mode=110, cnt=3, sin=1 held -> busy=1 for 3 enabled cycles, then q=8'h7F and done=1 for one cycle. Repeat with one en=0 cycle mid-burst -> done arrives one cycle later with the same q.
REQ-034 Burst corner cases: cnt=0 -> q unchanged and a done pulse on the next cycle. cnt=9 with sin=0 -> saturates to 8 shifts and q=8'h00. mode=111 mid-burst -> q=RESET_VAL, busy=0, no done.
REQ-035 Reset mid-burst: res=0 while busy=1 -> busy=0 and q=RESET_VAL immediately; no done pulse after release; a new load is accepted on the first enabled edge.
